// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit: producer end of the fetch -> decode valid/ready link.
// Issues word reads to instruction memory, remembers the PC of every request
// in flight, and buffers returned instructions with their PCs in an in-order
// FIFO whose head is presented to decode.
//
// Issue is credit based: a request is only made when both the outstanding
// request count and the FIFO space reserved for in-flight data leave room.
// Because of this, a returning response always has a free FIFO slot.
//
// A redirect flushes the FIFO and loads a new fetch PC. Requests already in
// flight cannot be cancelled at the memory, so their responses are counted
// off and discarded as they return (drop_cnt).
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   req_valid    out  memory read request valid (may be withdrawn)
//   req_ready    in   memory accepts request
//   req_addr     out  word-aligned fetch address
//   resp_valid   in   read data returned, in request order, one per cycle max
//   resp_data    in   instruction word
//   redirect     in   flush and refetch from redirect_pc
//   redirect_pc  in   new fetch address; bits [1:0] ignored
//   stall        in   decode stop: freezes delivery and issue
//   inst         out  instruction at FIFO head (0 when empty)
//   pc           out  PC of inst (0 when empty)
//   valid_next   out  inst/pc valid toward decode
//   ready_next   in   decode accepts
// -----------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid_next,
    input  logic        ready_next
);

    // Counter width holds 0..FIFO_DEPTH; MAX_OUTSTANDING <= FIFO_DEPTH so the
    // outstanding and drop counters share it.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] AQ_LAST = AW'(MAX_OUTSTANDING - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   fetch_pc_q,    fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q,    drop_cnt_d;

    // Address queue: PCs of issued requests, popped as responses return.
    logic [31:0]   aq_mem_q [MAX_OUTSTANDING];
    logic [AW-1:0] aq_wr_q, aq_wr_d;
    logic [AW-1:0] aq_rd_q, aq_rd_d;

    // Instruction FIFO: {pc, inst} pairs toward decode.
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];
    logic [FW-1:0] fifo_wr_q,  fifo_wr_d;
    logic [FW-1:0] fifo_rd_q,  fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic          fifo_empty;
    logic [CW:0]   credit_used;
    logic          issue_fire;
    logic          fifo_push;
    logic          fifo_pop;

    // Only the word address of redirect_pc is used.
    logic          redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign fifo_empty  = (fifo_cnt_q == '0);

    // Every in-flight request has a FIFO slot reserved for its response.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};

    assign req_valid   = ~rst & ~redirect & ~stall
                       & (outstanding_q < MAX_C)
                       & (credit_used < {1'b0, DEPTH_C});
    assign req_addr    = fetch_pc_q;
    assign issue_fire  = req_valid & req_ready;

    // Responses landing in a redirect cycle, or while older requests are still
    // being counted off, belong to the abandoned path.
    assign fifo_push   = resp_valid & ~redirect & (drop_cnt_q == '0);

    // Delivery is shown only from registered FIFO state, so a response is
    // visible to decode no earlier than the cycle after it arrives.
    assign valid_next  = ~rst & ~fifo_empty & ~stall & ~redirect;
    assign fifo_pop    = valid_next & ready_next;
    assign inst        = fifo_empty ? '0 : fifo_inst_q[fifo_rd_q];
    assign pc          = fifo_empty ? '0 : fifo_pc_q[fifo_rd_q];

    function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] p);
        return (p == AQ_LAST) ? '0 : p + AW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this
        // block leaves a signal unassigned and no latch is inferred.
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        aq_wr_d       = aq_wr_q;
        aq_rd_d       = aq_rd_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q;

        // issue_fire is already low during redirect.
        if (issue_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            aq_wr_d    = aq_next(aq_wr_q);
        end
        // The address queue is popped for every response, kept or dropped.
        if (resp_valid) begin
            aq_rd_d = aq_next(aq_rd_q);
        end
        outstanding_d = outstanding_q + CW'(issue_fire) - CW'(resp_valid);

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle is on the old path.
            drop_cnt_d = outstanding_q - CW'(resp_valid);
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (fifo_push) begin
                fifo_wr_d = fifo_wr_q + FW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_d = fifo_rd_q + FW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignment so every register samples the
    // pre-edge _d values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            aq_wr_q       <= '0;
            aq_rd_q       <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            aq_wr_q       <= aq_wr_d;
            aq_rd_q       <= aq_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone decide
    // which entries are live, and inst/pc are masked to 0 when empty.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            aq_mem_q[aq_wr_q] <= fetch_pc_q;
        end
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_q]   <= aq_mem_q[aq_rd_q];
            fifo_inst_q[fifo_wr_q] <= resp_data;
        end
    end

    // -------------------------------------------------------------------------
    // Design-error checks
    // -------------------------------------------------------------------------
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        fifo_push |-> (fifo_cnt_q != DEPTH_C));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= MAX_C);

    a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
        resp_valid |-> (outstanding_q != '0));

endmodule
